wb_mcb_arb: RTL and testbench
=============================

WB_MCB_ARB -- requirements
Module: wb_mcb_arb

Interface
REQ-001 Parameter DATA_WIDTH, default 32: Wishbone data width.
REQ-002 Parameter ADDR_WIDTH, default 32: Wishbone address width.
REQ-003 Parameter SELECT_WIDTH, default DATA_WIDTH/8: byte-select width.
REQ-004 Parameter TIMEOUT, default 64: stalled-strobe cycles before abort; legal range 2..65535.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 wbm0_adr_i/dat_i/we_i/sel_i/stb_i/cyc_i  input  ADDR_WIDTH/DATA_WIDTH/1/SELECT_WIDTH/1/1  master 0 request.
REQ-008 wbm0_dat_o/ack_o/err_o  output  DATA_WIDTH/1/1  master 0 response.
REQ-009 wbm1_* ports  same names, directions and widths as wbm0_*  master 1.
REQ-010 wbs_adr_o/dat_o/we_o/sel_o/stb_o/cyc_o  output  as wbm0 inputs  shared port toward the wb_mcb slave.
REQ-011 wbs_dat_i/ack_i  input  DATA_WIDTH/1  slave response.
REQ-012 grant_o  output  2  one-hot owner: 01 master 0, 10 master 1, 00 none.

Function
REQ-013 States SHALL be IDLE, OWN0, OWN1; grant_o is the decode of the state register.
REQ-014 IDLE: neither cyc_i -> stay; exactly one cyc_i -> that master's OWN state next edge.
REQ-015 IDLE, both cyc_i high -> grant master not owning last (last_owner register, reset to master 1 so master 0 wins first tie).
REQ-016 OWNn: owner cyc_i low at edge -> IDLE; cyc_i must drop before the other master can be granted (no direct OWN0<->OWN1).
REQ-017 Slave outputs SHALL be combinational muxes of the owner's adr/dat/we/sel/stb/cyc; in IDLE, stb_o and cyc_o are 0, others 0.
REQ-018 Grant latency: request seen in IDLE at edge N -> wbs_cyc_o high from edge N+1; back-to-back owner cyc kept with zero bubble.
REQ-019 wbs_ack_i SHALL route combinationally to the owner's ack_o only, gated by owner stb_i; non-owner ack_o and err_o are 0.
REQ-020 wbs_dat_i SHALL drive both wbm*_dat_o unconditionally; validity is qualified by ack_o.
REQ-021 Stall counter (16 bit): cleared when wbs_stb_o low or wbs_ack_i high; otherwise increments each cycle.
REQ-022 Counter reaching TIMEOUT-1 with stb high and ack low: owner err_o high that cycle, state -> IDLE next edge, counter cleared.
REQ-023 Ack and timeout in the same cycle: ack wins, no err.
REQ-024 wbs_ack_i arriving while IDLE SHALL be discarded (no ack_o to any master).
REQ-025 last_owner SHALL update on every entry into OWN0/OWN1.

Reset
REQ-026 rst_n low SHALL immediately (no clock edge) force state IDLE, grant_o 00, counter 0, last_owner master 1, making wbs_stb_o, wbs_cyc_o, all ack_o/err_o 0.
REQ-027 Reset deasserted mid-transfer: transfer abandoned; masters re-arbitrate from IDLE on first edge after release.

Verification
V-1 Master 0 single write adr 0x100, dat 0xDEADBEEF, sel 0xF; slave acks 2 cycles later -> grant_o 01 one cycle after cyc, wbs_adr_o 0x100, wbm0_ack_o one cycle, wbm1_ack_o 0.
V-2 Both cyc_i rise same cycle after reset -> master 0 granted; master 0 drops cyc -> IDLE one cycle -> master 1 granted; repeat tie -> master 0.
V-3 Master 1 burst of 4 reads holding cyc, slave returns 0x1..0x4 -> four wbm1_ack_o with matching dat_o, grant stays 10 throughout, master 0 held off.
V-4 TIMEOUT=8, slave never acks master 0 read -> wbm0_err_o high exactly one cycle, 8th stalled cycle; then IDLE, stray later wbs_ack_i ignored.
V-5 Ack on exactly the TIMEOUT-1 cycle -> ack_o high, err_o 0, state remains OWN0.
V-6 rst_n pulsed low mid-cycle during OWN1 -> grant_o 00 and wbs_cyc_o 0 asynchronously; after release, pending master 0 granted next edge.

Source files
------------

// File: rtl/wb_mcb_arb.sv
// wb_mcb_arb: two-master Wishbone arbiter in front of a single wb_mcb slave port.
//   Params : DATA_WIDTH, ADDR_WIDTH, SELECT_WIDTH, TIMEOUT (stalled strobe cycles before abort)
//   clk, rst_n         : clock, asynchronous active-low reset
//   wbm0_* / wbm1_*    : master request inputs (_i) and response outputs (_o)
//   wbs_*              : shared slave port (requests out, dat/ack in)
//   grant_o            : one-hot owner (01 master 0, 10 master 1, 00 none)
module wb_mcb_arb #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int SELECT_WIDTH = DATA_WIDTH / 8,
  parameter int TIMEOUT      = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ADDR_WIDTH-1:0]   wbm0_adr_i,
  input  logic [DATA_WIDTH-1:0]   wbm0_dat_i,
  input  logic                    wbm0_we_i,
  input  logic [SELECT_WIDTH-1:0] wbm0_sel_i,
  input  logic                    wbm0_stb_i,
  input  logic                    wbm0_cyc_i,
  output logic [DATA_WIDTH-1:0]   wbm0_dat_o,
  output logic                    wbm0_ack_o,
  output logic                    wbm0_err_o,
  input  logic [ADDR_WIDTH-1:0]   wbm1_adr_i,
  input  logic [DATA_WIDTH-1:0]   wbm1_dat_i,
  input  logic                    wbm1_we_i,
  input  logic [SELECT_WIDTH-1:0] wbm1_sel_i,
  input  logic                    wbm1_stb_i,
  input  logic                    wbm1_cyc_i,
  output logic [DATA_WIDTH-1:0]   wbm1_dat_o,
  output logic                    wbm1_ack_o,
  output logic                    wbm1_err_o,
  output logic [ADDR_WIDTH-1:0]   wbs_adr_o,
  output logic [DATA_WIDTH-1:0]   wbs_dat_o,
  output logic                    wbs_we_o,
  output logic [SELECT_WIDTH-1:0] wbs_sel_o,
  output logic                    wbs_stb_o,
  output logic                    wbs_cyc_o,
  input  logic [DATA_WIDTH-1:0]   wbs_dat_i,
  input  logic                    wbs_ack_i,
  output logic [1:0]              grant_o
);

  // State encoding doubles as the one-hot grant.
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_OWN0 = 2'b01;
  localparam logic [1:0] ST_OWN1 = 2'b10;

  localparam logic [15:0] STALL_LAST = 16'(TIMEOUT - 1);

  logic [1:0]  r_state;
  logic [1:0]  w_state_next;
  logic        r_last_owner;   // 0: master 0 owned last, 1: master 1
  logic [15:0] r_stall_cnt;
  logic        w_own0;
  logic        w_own1;
  logic        w_timeout;

  assign w_own0  = (r_state == ST_OWN0);
  assign w_own1  = (r_state == ST_OWN1);
  assign grant_o = r_state;

  always_comb begin
    wbs_adr_o = '0;
    wbs_dat_o = '0;
    wbs_we_o  = 1'b0;
    wbs_sel_o = '0;
    wbs_stb_o = 1'b0;
    wbs_cyc_o = 1'b0;
    if (w_own0) begin
      wbs_adr_o = wbm0_adr_i;
      wbs_dat_o = wbm0_dat_i;
      wbs_we_o  = wbm0_we_i;
      wbs_sel_o = wbm0_sel_i;
      wbs_stb_o = wbm0_stb_i;
      wbs_cyc_o = wbm0_cyc_i;
    end else if (w_own1) begin
      wbs_adr_o = wbm1_adr_i;
      wbs_dat_o = wbm1_dat_i;
      wbs_we_o  = wbm1_we_i;
      wbs_sel_o = wbm1_sel_i;
      wbs_stb_o = wbm1_stb_i;
      wbs_cyc_o = wbm1_cyc_i;
    end
  end

  // An ack in the final stall cycle suppresses the timeout.
  assign w_timeout = wbs_stb_o & ~wbs_ack_i & (r_stall_cnt == STALL_LAST);

  assign wbm0_dat_o = wbs_dat_i;
  assign wbm1_dat_o = wbs_dat_i;
  assign wbm0_ack_o = w_own0 & wbm0_stb_i & wbs_ack_i;
  assign wbm1_ack_o = w_own1 & wbm1_stb_i & wbs_ack_i;
  assign wbm0_err_o = w_own0 & w_timeout;
  assign wbm1_err_o = w_own1 & w_timeout;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (wbm0_cyc_i && wbm1_cyc_i)
          w_state_next = r_last_owner ? ST_OWN0 : ST_OWN1;
        else if (wbm0_cyc_i)
          w_state_next = ST_OWN0;
        else if (wbm1_cyc_i)
          w_state_next = ST_OWN1;
      end
      ST_OWN0: if (!wbm0_cyc_i || w_timeout) w_state_next = ST_IDLE;
      ST_OWN1: if (!wbm1_cyc_i || w_timeout) w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_last_owner <= 1'b1;
      r_stall_cnt  <= '0;
    end else begin
      r_state <= w_state_next;
      // OWN states are only entered from IDLE.
      if (r_state == ST_IDLE) begin
        if (w_state_next == ST_OWN0) r_last_owner <= 1'b0;
        if (w_state_next == ST_OWN1) r_last_owner <= 1'b1;
      end
      if (!wbs_stb_o || wbs_ack_i || w_timeout)
        r_stall_cnt <= '0;
      else
        r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_wb_mcb_arb.sv
module tb_wb_mcb_arb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] wbm0_adr_i, wbm0_dat_i, wbm1_adr_i, wbm1_dat_i;
  logic        wbm0_we_i, wbm0_stb_i, wbm0_cyc_i, wbm1_we_i, wbm1_stb_i, wbm1_cyc_i;
  logic [3:0]  wbm0_sel_i, wbm1_sel_i;
  logic [31:0] wbm0_dat_o, wbm1_dat_o;
  logic        wbm0_ack_o, wbm0_err_o, wbm1_ack_o, wbm1_err_o;
  logic [31:0] wbs_adr_o, wbs_dat_o, wbs_dat_i;
  logic        wbs_we_o, wbs_stb_o, wbs_cyc_o, wbs_ack_i;
  logic [3:0]  wbs_sel_o;
  logic [1:0]  grant_o;

  int errors = 0;
  int checks = 0;
  logic [32:0] exp_q[$];   // {master id, data} per expected ack

  wb_mcb_arb #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .SELECT_WIDTH(4), .TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .wbm0_adr_i(wbm0_adr_i), .wbm0_dat_i(wbm0_dat_i), .wbm0_we_i(wbm0_we_i),
    .wbm0_sel_i(wbm0_sel_i), .wbm0_stb_i(wbm0_stb_i), .wbm0_cyc_i(wbm0_cyc_i),
    .wbm0_dat_o(wbm0_dat_o), .wbm0_ack_o(wbm0_ack_o), .wbm0_err_o(wbm0_err_o),
    .wbm1_adr_i(wbm1_adr_i), .wbm1_dat_i(wbm1_dat_i), .wbm1_we_i(wbm1_we_i),
    .wbm1_sel_i(wbm1_sel_i), .wbm1_stb_i(wbm1_stb_i), .wbm1_cyc_i(wbm1_cyc_i),
    .wbm1_dat_o(wbm1_dat_o), .wbm1_ack_o(wbm1_ack_o), .wbm1_err_o(wbm1_err_o),
    .wbs_adr_o(wbs_adr_o), .wbs_dat_o(wbs_dat_o), .wbs_we_o(wbs_we_o),
    .wbs_sel_o(wbs_sel_o), .wbs_stb_o(wbs_stb_o), .wbs_cyc_o(wbs_cyc_o),
    .wbs_dat_i(wbs_dat_i), .wbs_ack_i(wbs_ack_i), .grant_o(grant_o)
  );

  always #5 clk = ~clk;

  // Ack monitor: every master ack must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (wbm0_ack_o && wbm1_ack_o) begin
        checks++; errors++;
        $display("FAIL dual_ack: both masters acked at %0t", $time);
      end else if (wbm0_ack_o || wbm1_ack_o) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_ack: m0=%b m1=%b with nothing expected at %0t",
                   wbm0_ack_o, wbm1_ack_o, $time);
        end else begin
          logic [32:0] exp_e, act_e;
          exp_e = exp_q.pop_front();
          act_e = wbm1_ack_o ? {1'b1, wbm1_dat_o} : {1'b0, wbm0_dat_o};
          if (act_e !== exp_e) begin
            errors++;
            $display("FAIL ack_data: got master/data %h, expected %h", act_e, exp_e);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp_v);
    end
  endtask

  task automatic clear_inputs();
    wbm0_adr_i = '0; wbm0_dat_i = '0; wbm0_we_i = 0; wbm0_sel_i = '0; wbm0_stb_i = 0; wbm0_cyc_i = 0;
    wbm1_adr_i = '0; wbm1_dat_i = '0; wbm1_we_i = 0; wbm1_sel_i = '0; wbm1_stb_i = 0; wbm1_cyc_i = 0;
    wbs_dat_i = '0; wbs_ack_i = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_grant", 32'(grant_o), 32'h0);
    chk("rst_cyc_stb", {30'b0, wbs_cyc_o, wbs_stb_o}, 32'h0);
    chk("rst_ack_err", {28'b0, wbm0_ack_o, wbm0_err_o, wbm1_ack_o, wbm1_err_o}, 32'h0);
    rst_n = 1;
  endtask

  task automatic test_single_write();
    tick();
    wbm0_adr_i = 32'h100; wbm0_dat_i = 32'hDEADBEEF; wbm0_sel_i = 4'hF;
    wbm0_we_i = 1; wbm0_stb_i = 1; wbm0_cyc_i = 1;
    #1 chk("v1_grant_before", 32'(grant_o), 32'h0);
    tick();
    chk("v1_grant", 32'(grant_o), 32'h1);
    chk("v1_adr", wbs_adr_o, 32'h100);
    chk("v1_dat", wbs_dat_o, 32'hDEADBEEF);
    chk("v1_sel_we_cyc", {26'b0, wbs_sel_o, wbs_we_o, wbs_cyc_o}, {26'b0, 4'hF, 2'b11});
    chk("v1_no_early_ack", 32'(wbm0_ack_o), 32'h0);
    tick();
    tick();
    wbs_ack_i = 1; wbs_dat_i = 32'h0;
    exp_q.push_back({1'b0, 32'h0});
    #1 chk("v1_ack", {30'b0, wbm0_ack_o, wbm1_ack_o}, 32'h2);
    tick();
    wbs_ack_i = 0; wbm0_cyc_i = 0; wbm0_stb_i = 0; wbm0_we_i = 0;
    #1 chk("v1_ack_drop", 32'(wbm0_ack_o), 32'h0);
    tick();
    chk("v1_idle", 32'(grant_o), 32'h0);
    chk("v1_queue_empty", exp_q.size(), 32'h0);
  endtask

  task automatic test_tie_break();
    test_reset();
    tick();
    wbm0_cyc_i = 1; wbm1_cyc_i = 1;
    tick();
    chk("v2_first_tie", 32'(grant_o), 32'h1);
    wbm0_cyc_i = 0;
    tick();
    chk("v2_no_direct_switch", 32'(grant_o), 32'h0);
    tick();
    chk("v2_m1_granted", 32'(grant_o), 32'h2);
    wbm1_cyc_i = 0;
    tick();
    chk("v2_idle_again", 32'(grant_o), 32'h0);
    wbm0_cyc_i = 1; wbm1_cyc_i = 1;
    tick();
    chk("v2_second_tie", 32'(grant_o), 32'h1);
    wbm0_cyc_i = 0; wbm1_cyc_i = 0;
    tick();
  endtask

  task automatic test_back_to_back();
    // Tie with master 0 owning last: master 1 wins, master 0 waits.
    wbm1_adr_i = 32'h200; wbm1_we_i = 0; wbm1_stb_i = 1; wbm1_cyc_i = 1;
    wbm0_adr_i = 32'h300; wbm0_we_i = 0; wbm0_stb_i = 1; wbm0_cyc_i = 1;
    tick();
    chk("v3_grant", 32'(grant_o), 32'h2);
    chk("v3_adr", wbs_adr_o, 32'h200);
    for (int i = 1; i <= 4; i++) begin
      wbs_ack_i = 1; wbs_dat_i = 32'(i);
      exp_q.push_back({1'b1, 32'(i)});
      #1 chk("v3_burst_ack", {30'b0, wbm1_ack_o, wbm0_ack_o}, 32'h2);
      tick();
      chk("v3_grant_held", 32'(grant_o), 32'h2);
    end
    wbs_ack_i = 0; wbm1_cyc_i = 0; wbm1_stb_i = 0;
    tick();
    chk("v3_idle_bubble", 32'(grant_o), 32'h0);
    tick();
    chk("v3_m0_after", 32'(grant_o), 32'h1);
    wbm0_cyc_i = 0; wbm0_stb_i = 0;
    tick();
    chk("v3_idle_end", 32'(grant_o), 32'h0);
    chk("v3_queue_empty", exp_q.size(), 32'h0);
  endtask

  task automatic test_timeout();
    wbm0_adr_i = 32'h400; wbm0_we_i = 0; wbm0_stb_i = 1; wbm0_cyc_i = 1;
    tick();
    chk("v4_grant", 32'(grant_o), 32'h1);
    for (int i = 1; i <= 7; i++) begin
      chk("v4_no_err_early", 32'(wbm0_err_o), 32'h0);
      tick();
    end
    chk("v4_err_8th", {30'b0, wbm0_err_o, wbm1_err_o}, 32'h2);
    tick();
    chk("v4_abort_idle", 32'(grant_o), 32'h0);
    chk("v4_err_one_cycle", 32'(wbm0_err_o), 32'h0);
    wbm0_cyc_i = 0; wbm0_stb_i = 0;
    wbs_ack_i = 1; wbs_dat_i = 32'hBAD;
    #1 chk("v4_stray_ack", {30'b0, wbm0_ack_o, wbm1_ack_o}, 32'h0);
    tick();
    wbs_ack_i = 0;
    chk("v4_still_idle", 32'(grant_o), 32'h0);
  endtask

  task automatic test_ack_at_limit();
    wbm0_adr_i = 32'h500; wbm0_stb_i = 1; wbm0_cyc_i = 1;
    tick();
    chk("v5_grant", 32'(grant_o), 32'h1);
    repeat (7) tick();
    wbs_ack_i = 1; wbs_dat_i = 32'h55;
    exp_q.push_back({1'b0, 32'h55});
    #1 chk("v5_ack_not_err", {30'b0, wbm0_ack_o, wbm0_err_o}, 32'h2);
    tick();
    wbs_ack_i = 0;
    chk("v5_stays_own0", 32'(grant_o), 32'h1);
    #1 chk("v5_no_err_after", 32'(wbm0_err_o), 32'h0);
    wbm0_cyc_i = 0; wbm0_stb_i = 0;
    tick();
    chk("v5_idle", 32'(grant_o), 32'h0);
    chk("v5_queue_empty", exp_q.size(), 32'h0);
  endtask

  task automatic test_async_reset();
    wbm1_cyc_i = 1; wbm1_stb_i = 1;
    tick();
    chk("v6_own1", 32'(grant_o), 32'h2);
    wbm0_cyc_i = 1; wbm0_stb_i = 1;
    #2 rst_n = 0;
    #1 chk("v6_async_grant", 32'(grant_o), 32'h0);
    chk("v6_async_cyc", {30'b0, wbs_cyc_o, wbs_stb_o}, 32'h0);
    #2 rst_n = 1;
    tick();
    chk("v6_m0_after_release", 32'(grant_o), 32'h1);
    clear_inputs();
    tick();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_single_write();
    test_tie_break();
    test_back_to_back();
    test_timeout();
    test_ack_at_limit();
    test_async_reset();
    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
